// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin share of one SDRAM controller user port between NPORT requesters, read data routed back by tag.
// Latency: p_req -> ctrl_req 1 cycle, ctrl_rvalid -> p_rvalid 1 cycle; at most one request every 2 cycles.
// Backpressure: ctrl_* held until ctrl_ready; reads are not granted while RD_DEPTH reads are outstanding.
// Build option: define SDRAM_ARB_PRIO0_EN to give port 0 strict priority over the round-robin ports.

// Small in-order FIFO holding the source port of each outstanding read.
module sdram_arbiter_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_vld,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_ok, push_ok;

    // Pointer/count update; a pop frees a slot for a same-cycle push.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        pop_ok   = pop_vld && (cnt_q != '0);
        push_ok  = push_vld && ((cnt_q != CW'(DEPTH)) || pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // FIFO state register; reset discards every stored tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = cnt_q;
endmodule

module sdram_arbiter #(
    parameter int NPORT    = 2,
    parameter int AW       = 23,
    parameter int DW       = 16,
    parameter int RD_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    p_req,
    input  logic [NPORT-1:0]    p_write,
    input  logic [NPORT*AW-1:0] p_addr,
    input  logic [NPORT*DW-1:0] p_wdata,
    output logic [NPORT-1:0]    p_ready,
    output logic [NPORT-1:0]    p_rvalid,
    output logic [DW-1:0]       p_rdata,
    output logic                ctrl_req,
    output logic                ctrl_write,
    output logic [AW-1:0]       ctrl_addr,
    output logic [DW-1:0]       ctrl_wdata,
    input  logic                ctrl_ready,
    input  logic                ctrl_rvalid,
    input  logic [DW-1:0]       ctrl_rdata,
    output logic                rsp_err
);
    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW = $clog2(RD_DEPTH) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     gnt_id_q, gnt_id_d;
    logic              ctrl_req_q, ctrl_req_d;
    logic              ctrl_write_q, ctrl_write_d;
    logic [AW-1:0]     ctrl_addr_q, ctrl_addr_d;
    logic [DW-1:0]     ctrl_wdata_q, ctrl_wdata_d;
    logic [NPORT-1:0]  p_rvalid_q, p_rvalid_d;
    logic [DW-1:0]     p_rdata_q, p_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [NPORT-1:0]  elig;
    logic              win_vld;
    logic [IW-1:0]     win_id;
    logic              accept;
    logic              tag_push, tag_pop;
    logic [IW-1:0]     tag_head;
    logic [CW-1:0]     tag_cnt;

    // A read is only eligible while a tag slot is free (count before any same-cycle pop).
    always_comb begin
        elig = '0;
        for (int i = 0; i < NPORT; i++) begin
            elig[i] = p_req[i] && (p_write[i] || (tag_cnt < CW'(RD_DEPTH)));
        end
    end

    // Winner: first eligible port at or after rr_ptr, wrapping; port 0 may override.
    always_comb begin
        logic [NPORT-1:0] rr_elig;
        logic [IW:0]      idx;
        win_vld = 1'b0;
        win_id  = '0;
        rr_elig = elig;
`ifdef SDRAM_ARB_PRIO0_EN
        rr_elig[0] = 1'b0;
`endif
        for (int k = 0; k < NPORT; k++) begin
            idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(NPORT)) idx = idx - (IW+1)'(NPORT);
            if (!win_vld && rr_elig[idx[IW-1:0]]) begin
                win_vld = 1'b1;
                win_id  = idx[IW-1:0];
            end
        end
`ifdef SDRAM_ARB_PRIO0_EN
        if (elig[0]) begin
            win_vld = 1'b1;
            win_id  = '0;
        end
`endif
    end

    // Grant FSM: latch the winner's request in IDLE, hold it in GRANT until accepted.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_id_d     = gnt_id_q;
        ctrl_req_d   = ctrl_req_q;
        ctrl_write_d = ctrl_write_q;
        ctrl_addr_d  = ctrl_addr_q;
        ctrl_wdata_d = ctrl_wdata_q;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d      = GRANT;
                    gnt_id_d     = win_id;
                    ctrl_req_d   = 1'b1;
                    ctrl_write_d = p_write[win_id];
                    ctrl_addr_d  = p_addr[win_id*AW +: AW];
                    ctrl_wdata_d = p_wdata[win_id*DW +: DW];
                end
            end
            GRANT: begin
                if (ctrl_ready) begin
                    accept     = 1'b1;
                    state_d    = IDLE;
                    ctrl_req_d = 1'b0;
`ifdef SDRAM_ARB_PRIO0_EN
                    if (gnt_id_q != '0)
`endif
                    rr_ptr_d = (gnt_id_q == IW'(NPORT - 1)) ? '0 : gnt_id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read return: pop the head tag and present the data to that port next cycle.
    always_comb begin
        p_rvalid_d = '0;
        p_rdata_d  = p_rdata_q;
        rsp_err_d  = rsp_err_q;
        if (tag_pop) begin
            p_rvalid_d = NPORT'(1) << tag_head;
            p_rdata_d  = ctrl_rdata;
        end else if (ctrl_rvalid) begin
            rsp_err_d = 1'b1;
        end
    end

    // Acceptance strobe to the granted port; suppressed while reset abandons the request.
    always_comb begin
        p_ready = '0;
        if (accept && !rst) p_ready = NPORT'(1) << gnt_id_q;
    end

    assign tag_push = accept && !ctrl_write_q;
    assign tag_pop  = ctrl_rvalid && (tag_cnt != '0);

    sdram_arbiter_tag_fifo #(
        .W     (IW),
        .DEPTH (RD_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (tag_push),
        .push_dat (gnt_id_q),
        .pop_vld  (tag_pop),
        .head_dat (tag_head),
        .count    (tag_cnt)
    );

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_id_q     <= '0;
            ctrl_req_q   <= 1'b0;
            ctrl_write_q <= 1'b0;
            ctrl_addr_q  <= '0;
            ctrl_wdata_q <= '0;
            p_rvalid_q   <= '0;
            p_rdata_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_id_q     <= gnt_id_d;
            ctrl_req_q   <= ctrl_req_d;
            ctrl_write_q <= ctrl_write_d;
            ctrl_addr_q  <= ctrl_addr_d;
            ctrl_wdata_q <= ctrl_wdata_d;
            p_rvalid_q   <= p_rvalid_d;
            p_rdata_q    <= p_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign ctrl_req   = ctrl_req_q;
    assign ctrl_write = ctrl_write_q;
    assign ctrl_addr  = ctrl_addr_q;
    assign ctrl_wdata = ctrl_wdata_q;
    assign p_rvalid   = p_rvalid_q;
    assign p_rdata    = p_rdata_q;
    assign rsp_err    = rsp_err_q;
endmodule
